// File: rtl/pll_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq_pkg
// Description : Shared state encodings and elaboration-time helpers for the
//               PLL lock supervisor / reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_seq_pkg;

    localparam int C_ST_W = 3;

    localparam logic [C_ST_W-1:0] C_ST_PLL_RST   = 3'd0;
    localparam logic [C_ST_W-1:0] C_ST_WAIT_LOCK = 3'd1;
    localparam logic [C_ST_W-1:0] C_ST_RELEASE   = 3'd2;
    localparam logic [C_ST_W-1:0] C_ST_RUN       = 3'd3;
    localparam logic [C_ST_W-1:0] C_ST_SW_HOLD   = 3'd4;

    // Largest of three cycle counts, used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_seq_cdc_sync2.sv
`default_nettype none
// ============================================================================
// Module      : cdc_sync2
// Description : Parametrised-width two-flop synchroniser with synchronous
//               active-low clear. Reusable for any asynchronous level input.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : PLL lock supervisor and multi-domain reset sequencer. Holds
//               the PLL in reset, waits for a stable lock, then releases the
//               reset domains one by one. Lock loss restarts the PLL; a
//               software warm reset re-sequences the domains only.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int N_DOMAINS          = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int RELEASE_GAP        = 8,
    parameter int CNT_W              = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pll_locked,
    input  logic                 sw_reset_req,
    output logic                 pll_resetb,
    output logic [N_DOMAINS-1:0] domain_resetn,
    output logic                 ready,
    output logic [CNT_W-1:0]     lock_loss_cnt,
    output logic [CNT_W-1:0]     retry_cnt
);

    // One phase counter serves PLL_RST, SW_HOLD, WAIT_LOCK timeout and the
    // release gap, since only one of them is active at a time.
    localparam int C_CYC_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, RELEASE_GAP);
    localparam int C_CYC_W   = $clog2(C_CYC_MAX + 1);
    localparam int C_STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_SAT = {CNT_W{1'b1}};

    logic [C_ST_W-1:0]    r_state;
    logic [C_CYC_W-1:0]   r_cnt;
    logic [C_STB_W-1:0]   r_stable;
    logic                 r_pll_resetb;
    logic [N_DOMAINS-1:0] r_domain_resetn;
    logic                 r_ready;
    logic [CNT_W-1:0]     r_lock_loss_cnt;
    logic [CNT_W-1:0]     r_retry_cnt;

    logic                 w_lock_s;
    logic [C_CYC_W-1:0]   w_cnt_inc;
    logic [C_STB_W-1:0]   w_stable_inc;
    logic                 w_live;
    logic                 w_hold;

    cdc_sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (pll_locked),
        .o_q    (w_lock_s)
    );

    assign w_cnt_inc    = r_cnt + C_CYC_W'(1);
    assign w_stable_inc = r_stable + C_STB_W'(1);
    assign w_live       = (r_state == C_ST_RELEASE) || (r_state == C_ST_RUN);
    assign w_hold       = (r_state == C_ST_SW_HOLD);

    // Sequencer FSM; lock loss outranks warm reset, which outranks progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= C_ST_PLL_RST;
            r_cnt           <= '0;
            r_stable        <= '0;
            r_pll_resetb    <= 1'b0;
            r_domain_resetn <= '0;
            r_ready         <= 1'b0;
            r_lock_loss_cnt <= '0;
            r_retry_cnt     <= '0;
        end else if ((w_live || w_hold) && !w_lock_s) begin
            r_state         <= C_ST_PLL_RST;
            r_cnt           <= '0;
            r_stable        <= '0;
            r_pll_resetb    <= 1'b0;
            r_domain_resetn <= '0;
            r_ready         <= 1'b0;
            if (r_lock_loss_cnt != C_CNT_SAT) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + CNT_W'(1);
            end
        end else if (w_live && sw_reset_req) begin
            r_state         <= C_ST_SW_HOLD;
            r_cnt           <= '0;
            r_domain_resetn <= '0;
            r_ready         <= 1'b0;
        end else begin
            case (r_state)
                C_ST_PLL_RST: begin
                    if (w_cnt_inc == C_CYC_W'(PLL_RST_CYCLES)) begin
                        r_state      <= C_ST_WAIT_LOCK;
                        r_cnt        <= '0;
                        r_stable     <= '0;
                        r_pll_resetb <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                C_ST_WAIT_LOCK: begin
                    if (w_lock_s && (w_stable_inc == C_STB_W'(LOCK_STABLE_CYCLES))) begin
                        // Bit 0 goes up on the same edge that enters RELEASE.
                        r_state         <= C_ST_RELEASE;
                        r_cnt           <= '0;
                        r_stable        <= '0;
                        r_domain_resetn <= N_DOMAINS'(1);
                    end else if (w_cnt_inc == C_CYC_W'(LOCK_TIMEOUT)) begin
                        r_state      <= C_ST_PLL_RST;
                        r_cnt        <= '0;
                        r_stable     <= '0;
                        r_pll_resetb <= 1'b0;
                        if (r_retry_cnt != C_CNT_SAT) begin
                            r_retry_cnt <= r_retry_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt    <= w_cnt_inc;
                        r_stable <= w_lock_s ? w_stable_inc : '0;
                    end
                end
                C_ST_RELEASE: begin
                    if (w_cnt_inc == C_CYC_W'(RELEASE_GAP)) begin
                        r_cnt <= '0;
                        if (&r_domain_resetn) begin
                            r_state <= C_ST_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            // Shift a one in so released bits stay high.
                            r_domain_resetn <= (r_domain_resetn << 1) | N_DOMAINS'(1);
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                C_ST_RUN: begin
                    r_cnt <= '0;
                end
                C_ST_SW_HOLD: begin
                    if (w_cnt_inc == C_CYC_W'(PLL_RST_CYCLES)) begin
                        r_state         <= C_ST_RELEASE;
                        r_cnt           <= '0;
                        r_domain_resetn <= N_DOMAINS'(1);
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state         <= C_ST_PLL_RST;
                    r_cnt           <= '0;
                    r_stable        <= '0;
                    r_pll_resetb    <= 1'b0;
                    r_domain_resetn <= '0;
                    r_ready         <= 1'b0;
                end
            endcase
        end
    end

    assign pll_resetb    = r_pll_resetb;
    assign domain_resetn = r_domain_resetn;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_lock_loss_cnt;
    assign retry_cnt     = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pll_reset_seq
// Description : Self-checking bench for pll_reset_seq: directed scenarios with
//               literal expectations plus randomized lock/warm-reset traffic
//               compared every cycle against a time-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    localparam int N  = 3;
    localparam int P  = 4;
    localparam int S  = 8;
    localparam int T  = 32;
    localparam int G  = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          pll_locked;
    logic          sw_reset_req;
    logic          pll_resetb;
    logic [N-1:0]  domain_resetn;
    logic          ready;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] retry_cnt;

    logic          sat_resetn;
    logic          sat_locked;
    logic          sat_sw;
    logic          sat_pll_resetb;
    logic [N-1:0]  sat_dom;
    logic          sat_ready;
    logic [CW-1:0] sat_loss;
    logic [CW-1:0] sat_retry;
    bit            sat_done = 1'b0;

    int checks   = 0;
    int failures = 0;

    pll_reset_seq #(
        .N_DOMAINS(N), .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(S),
        .LOCK_TIMEOUT(T), .RELEASE_GAP(G), .CNT_W(CW)
    ) dut (
        .clk(clk), .resetn(resetn), .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req), .pll_resetb(pll_resetb),
        .domain_resetn(domain_resetn), .ready(ready),
        .lock_loss_cnt(lock_loss_cnt), .retry_cnt(retry_cnt)
    );

    pll_reset_seq #(
        .N_DOMAINS(N), .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(S),
        .LOCK_TIMEOUT(2), .RELEASE_GAP(G), .CNT_W(CW)
    ) dut_sat (
        .clk(clk), .resetn(sat_resetn), .pll_locked(sat_locked),
        .sw_reset_req(sat_sw), .pll_resetb(sat_pll_resetb),
        .domain_resetn(sat_dom), .ready(sat_ready),
        .lock_loss_cnt(sat_loss), .retry_cnt(sat_retry)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 PLL held in reset, 1 waiting for lock, 2 domains released
    // (running once all are out), 3 warm-reset hold. m_t counts edges since
    // the mode was entered; outputs are derived from it arithmetically.
    int   m_mode  = 0;
    int   m_t     = 0;
    int   m_run   = 0;
    int   m_loss  = 0;
    int   m_retry = 0;
    logic m_h1    = 1'b0;
    logic m_h2    = 1'b0;
    logic m_ls;
    bit   m_valid = 1'b0;

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic logic m_prb();
        return (m_mode != 0);
    endfunction

    function automatic logic m_rdy();
        return (m_mode == 2) && (m_t >= N * G);
    endfunction

    function automatic logic [N-1:0] m_dom();
        int k;
        logic [N-1:0] v;
        v = '0;
        if (m_mode == 2) begin
            k = m_t / G + 1;
            if (k > N) k = N;
            for (int i = 0; i < k; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_mode = 0; m_t = 0; m_run = 0; m_loss = 0; m_retry = 0;
                m_h1 = 1'b0; m_h2 = 1'b0; m_valid = 1'b1;
            end else begin
                m_ls = m_h2;
                m_h2 = m_h1;
                m_h1 = pll_locked;
                case (m_mode)
                    0: begin
                        m_t++;
                        if (m_t == P) begin m_mode = 1; m_t = 0; m_run = 0; end
                    end
                    1: begin
                        m_t++;
                        m_run = m_ls ? m_run + 1 : 0;
                        if (m_run == S) begin
                            m_mode = 2; m_t = 0;
                        end else if (m_t == T) begin
                            m_retry = sat_inc(m_retry); m_mode = 0; m_t = 0;
                        end
                    end
                    2: begin
                        if (!m_ls) begin
                            m_loss = sat_inc(m_loss); m_mode = 0; m_t = 0;
                        end else if (sw_reset_req) begin
                            m_mode = 3; m_t = 0;
                        end else if (m_t < 100000) begin
                            m_t++;
                        end
                    end
                    default: begin
                        if (!m_ls) begin
                            m_loss = sat_inc(m_loss); m_mode = 0; m_t = 0;
                        end else begin
                            m_t++;
                            if (m_t == P) begin m_mode = 2; m_t = 0; end
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [20:0] cmp_act;
    logic [20:0] cmp_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                cmp_act = {pll_resetb, domain_resetn, ready, lock_loss_cnt, retry_cnt};
                cmp_exp = {m_prb(), m_dom(), m_rdy(), CW'(m_loss), CW'(m_retry)};
                checks++;
                if (cmp_act !== cmp_exp) begin
                    failures++;
                    $display("FAIL model_cmp t=%0t: got prb/dom/rdy/loss/retry=%0b/%b/%0b/%0d/%0d expected %0b/%b/%0b/%0d/%0d",
                             $time, cmp_act[20], cmp_act[19:17], cmp_act[16], cmp_act[15:8], cmp_act[7:0],
                             cmp_exp[20], cmp_exp[19:17], cmp_exp[16], cmp_exp[15:8], cmp_exp[7:0]);
                end
            end
        end
    end

    // Literal check against both the DUT and the model.
    task automatic check_lit(input string name, input int act, input int mdl, input int exp);
        checks += 2;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (dut): got %0d expected %0d", name, act, exp);
        end
        if (mdl != exp) begin
            failures++;
            $display("FAIL %s (model): got %0d expected %0d", name, mdl, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic lock);
        resetn       = 1'b0;
        pll_locked   = lock;
        sw_reset_req = 1'b0;
        step(2);
        resetn = 1'b1;
    endtask

    // ---------------- saturation instance ----------------
    initial begin
        sat_resetn = 1'b0;
        sat_locked = 1'b0;
        sat_sw     = 1'b0;
        step(2);
        sat_resetn = 1'b1;
        // Timeouts land every 6 edges (4 reset + 2 wait) after release.
        step(600);
        checks++;
        if (sat_retry !== 8'd100) begin
            failures++;
            $display("FAIL sat_retry_600: got %0d expected 100", sat_retry);
        end
        step(1400);
        checks++;
        if (sat_retry !== 8'd255) begin
            failures++;
            $display("FAIL sat_retry_sat: got %0d expected 255", sat_retry);
        end
        sat_done = 1'b1;
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        resetn = 1'b0; pll_locked = 1'b0; sw_reset_req = 1'b0;

        // Cold boot with lock present from the start.
        resetn = 1'b0; pll_locked = 1'b1; sw_reset_req = 1'b0;
        step(2);
        check_lit("rst_prb",   pll_resetb,    m_prb(), 0);
        check_lit("rst_dom",   domain_resetn, m_dom(), 0);
        check_lit("rst_rdy",   ready,         m_rdy(), 0);
        check_lit("rst_loss",  lock_loss_cnt, m_loss,  0);
        check_lit("rst_retry", retry_cnt,     m_retry, 0);
        resetn = 1'b1;
        step(3);  check_lit("boot_prb_e3",  pll_resetb,    m_prb(), 0);
        step(1);  check_lit("boot_prb_e4",  pll_resetb,    m_prb(), 1);
        step(7);  check_lit("boot_dom_e11", domain_resetn, m_dom(), 0);
        step(1);  check_lit("boot_dom_e12", domain_resetn, m_dom(), 1);
        step(2);  check_lit("boot_dom_e14", domain_resetn, m_dom(), 3);
        step(2);  check_lit("boot_dom_e16", domain_resetn, m_dom(), 7);
                  check_lit("boot_rdy_e16", ready,         m_rdy(), 0);
        step(2);  check_lit("boot_rdy_e18", ready,         m_rdy(), 1);
                  check_lit("boot_cnts",    lock_loss_cnt + retry_cnt, m_loss + m_retry, 0);

        // Lock drop in RUN.
        pll_locked = 1'b0;
        step(2);  check_lit("drop_rdy_f2",  ready,         m_rdy(), 1);
        step(1);  check_lit("drop_rdy_f3",  ready,         m_rdy(), 0);
                  check_lit("drop_dom_f3",  domain_resetn, m_dom(), 0);
                  check_lit("drop_prb_f3",  pll_resetb,    m_prb(), 0);
                  check_lit("drop_loss",    lock_loss_cnt, m_loss,  1);
        pll_locked = 1'b1;
        step(3);  check_lit("drop_prb_f6",  pll_resetb,    m_prb(), 0);
        step(1);  check_lit("drop_prb_f7",  pll_resetb,    m_prb(), 1);
        step(8);  check_lit("drop_dom_f15", domain_resetn, m_dom(), 1);
        step(6);  check_lit("drop_rdy_f21", ready,         m_rdy(), 1);

        // Warm reset in RUN.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
                  check_lit("sw_dom_s1",  domain_resetn, m_dom(), 0);
                  check_lit("sw_prb_s1",  pll_resetb,    m_prb(), 1);
        step(3);  check_lit("sw_dom_s4",  domain_resetn, m_dom(), 0);
        step(1);  check_lit("sw_dom_s5",  domain_resetn, m_dom(), 1);
        step(2);  check_lit("sw_dom_s7",  domain_resetn, m_dom(), 3);
        step(2);  check_lit("sw_dom_s9",  domain_resetn, m_dom(), 7);
        step(2);  check_lit("sw_rdy_s11", ready,         m_rdy(), 1);
                  check_lit("sw_loss",    lock_loss_cnt, m_loss,  1);

        // Warm reset coinciding with the synchronised lock drop.
        pll_locked = 1'b0;
        step(2);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
                  check_lit("both_prb",  pll_resetb,    m_prb(), 0);
                  check_lit("both_loss", lock_loss_cnt, m_loss,  2);
        pll_locked = 1'b1;
        step(12); check_lit("both_dom_rel", domain_resetn, m_dom(), 1);

        // resetn mid-RELEASE.
        resetn = 1'b0;
        step(1);
                  check_lit("mid_prb",   pll_resetb,    m_prb(), 0);
                  check_lit("mid_dom",   domain_resetn, m_dom(), 0);
                  check_lit("mid_loss",  lock_loss_cnt, m_loss,  0);
        resetn = 1'b1;

        // Lock glitch while waiting.
        do_reset(1'b0);
        step(4);  pll_locked = 1'b1;
        step(6);  pll_locked = 1'b0;
        step(1);  pll_locked = 1'b1;
        step(9);  check_lit("glitch_dom_e20", domain_resetn, m_dom(), 0);
        step(1);  check_lit("glitch_dom_e21", domain_resetn, m_dom(), 1);
                  check_lit("glitch_retry",   retry_cnt,     m_retry, 0);

        // No lock at all: periodic retries.
        do_reset(1'b0);
        step(107); check_lit("tmo_retry_e107", retry_cnt,     m_retry, 2);
        step(1);   check_lit("tmo_retry_e108", retry_cnt,     m_retry, 3);
                   check_lit("tmo_prb_e108",   pll_resetb,    m_prb(), 0);
        step(4);   check_lit("tmo_prb_e112",   pll_resetb,    m_prb(), 1);
                   check_lit("tmo_dom",        domain_resetn, m_dom(), 0);

        // Randomized traffic.
        do_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 99) < 2) pll_locked = 1'b0;
            end else if ($urandom_range(0, 99) < ((i < 1500) ? 20 : 3)) begin
                pll_locked = 1'b1;
            end
            sw_reset_req = ($urandom_range(0, 39) == 0);
            resetn       = ($urandom_range(0, 1499) != 0);
            step(1);
        end
        resetn = 1'b1; sw_reset_req = 1'b0;

        for (int i = 0; i < 5000 && !sat_done; i++) step(1);
        checks++;
        if (!sat_done) begin
            failures++;
            $display("FAIL sat_wait: got done=0 expected done=1");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
